// File: rtl/adc_sequencer.sv
`timescale 1ns/1ps
// adc_sequencer: ADC clock divider, analog mux / hall phase sequencing, SOC/EOC handshake and result capture.
// Define ADC_SPINNING_EN to spin channels 2..4 over four plate phases and average the results.
module adc_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic        ms_osc,
    input  logic        ms_hporb,
    input  logic        start,
    input  logic [4:0]  ch_en,
    output logic        busy,
    output logic        err,
    output logic        res_valid,
    output logic [2:0]  res_chan,
    output logic [11:0] res_data,
    output logic        ms_adc_clk,
    output logic        ms_adc_soc,
    input  logic        ms_adc_eoc,
    input  logic [11:0] ms_adc_data,
    output logic [3:0]  ms_afe_sel,
    output logic [3:0]  ms_afe_phase,
    output logic        ms_afe_phase_update
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + SETTLE + 2 * CLK_DIV + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SOC, S_WAIT, S_STORE, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_adc_clk;
    logic [CNT_W-1:0] r_cnt;
    logic             r_soc;
    logic [2:0]       r_eoc_sync;
    logic [4:0]       r_ch_en;
    logic [2:0]       r_ch;
    logic [3:0]       r_sel;
    logic [13:0]      r_acc;
    logic             r_discard;
    logic             r_busy, r_err, r_res_valid;
    logic [2:0]       r_res_chan;
    logic [11:0]      r_res_data;

    logic        w_adc_rise, w_start_ok, w_settle_done, w_soc_done, w_eoc_rise, w_timeout;
    logic        w_spun, w_last_phase, w_phase_step, w_has_next;
    logic [2:0]  w_first_ch, w_next_ch;
    logic [13:0] w_sum;

    function automatic logic [3:0] sel_of(input logic [2:0] ch);
        case (ch)
            3'd0:    return 4'd1;
            3'd1:    return 4'd2;
            3'd2:    return 4'd4;
            3'd3:    return 4'd5;
            3'd4:    return 4'd6;
            default: return 4'd0;
        endcase
    endfunction

    assign w_adc_rise    = !r_adc_clk && (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_start_ok    = start && (ch_en != 5'd0);
    assign w_settle_done = (r_cnt == CNT_W'(SETTLE - 1));
    assign w_soc_done    = r_soc && (r_cnt == CNT_W'(2 * CLK_DIV - 1));
    assign w_eoc_rise    = r_eoc_sync[1] && !r_eoc_sync[2];
    assign w_timeout     = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_sum         = r_acc + 14'(ms_adc_data);
    assign w_phase_step  = (r_state == S_STORE) && !r_discard && !w_last_phase;

    // Lowest enabled index at start, and the next enabled index above the current channel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_first_ch = 3'd0;
        w_next_ch  = 3'd0;
        w_has_next = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (ch_en[i]) w_first_ch = 3'(i);
            if (r_ch_en[i] && (3'(i) > r_ch)) begin
                w_next_ch  = 3'(i);
                w_has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge ms_osc or negedge ms_hporb) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!ms_hporb) begin
            r_div_cnt  <= '0;
            r_adc_clk  <= 1'b0;
            r_eoc_sync <= 3'b000;
        end else begin
            r_eoc_sync <= {r_eoc_sync[1:0], ms_adc_eoc};
            if (r_div_cnt == DIV_W'(CLK_DIV - 1)) begin
                r_div_cnt <= '0;
                r_adc_clk <= !r_adc_clk;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge ms_osc or negedge ms_hporb) begin
        if (!ms_hporb) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_SETUP;
            S_SETUP: if (w_settle_done) w_state_nxt = S_SOC;
            S_SOC:   if (w_soc_done) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_eoc_rise || w_timeout) w_state_nxt = S_STORE;
            S_STORE: w_state_nxt = (w_phase_step || w_has_next) ? S_SETUP : S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ms_osc or negedge ms_hporb) begin
        if (!ms_hporb) begin
            r_cnt       <= '0;
            r_soc       <= 1'b0;
            r_ch_en     <= 5'd0;
            r_ch        <= 3'd0;
            r_sel       <= 4'd0;
            r_acc       <= 14'd0;
            r_discard   <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_chan  <= 3'd0;
            r_res_data  <= 12'd0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start_ok) begin
                    r_ch_en <= ch_en;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_ch    <= w_first_ch;
                    r_sel   <= sel_of(w_first_ch);
                    r_cnt   <= '0;
                end
                S_SETUP: r_cnt <= w_settle_done ? '0 : r_cnt + 1'b1;
                S_SOC: begin
                    // SOC is launched on an ADC clock rising edge and spans one full ADC period.
                    if (r_soc) begin
                        if (w_soc_done) begin
                            r_soc <= 1'b0;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_adc_rise) begin
                        r_soc <= 1'b1;
                        r_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_eoc_rise) begin
                        r_discard <= 1'b0;
                        r_acc     <= w_sum;
                        if (w_last_phase) begin
                            r_res_valid <= 1'b1;
                            r_res_chan  <= r_ch;
                            r_res_data  <= w_spun ? w_sum[13:2] : ms_adc_data;
                        end
                    end else if (w_timeout) begin
                        r_err     <= 1'b1;
                        r_discard <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STORE: begin
                    r_cnt <= '0;
                    if (!w_phase_step) begin
                        r_acc <= 14'd0;
                        if (w_has_next) begin
                            r_ch  <= w_next_ch;
                            r_sel <= sel_of(w_next_ch);
                        end else begin
                            r_busy <= 1'b0;
                            r_sel  <= 4'd0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADC_SPINNING_EN
    logic [3:0] r_phase;
    logic       r_phase_upd;

    assign w_spun       = (r_ch >= 3'd2);
    assign w_last_phase = !w_spun || r_phase[3];

    // Returning to phase 0001 between channels is a park, not a spin step, so it does not strobe.
    always_ff @(posedge ms_osc or negedge ms_hporb) begin
        if (!ms_hporb) begin
            r_phase     <= 4'b0001;
            r_phase_upd <= 1'b0;
        end else begin
            r_phase_upd <= 1'b0;
            if (w_phase_step) begin
                r_phase     <= {r_phase[2:0], 1'b0};
                r_phase_upd <= 1'b1;
            end else if (r_state == S_STORE) begin
                r_phase <= 4'b0001;
            end
        end
    end

    assign ms_afe_phase        = r_phase;
    assign ms_afe_phase_update = r_phase_upd;
`else
    assign w_spun              = 1'b0;
    assign w_last_phase        = 1'b1;
    assign ms_afe_phase        = 4'b0001;
    assign ms_afe_phase_update = 1'b0;
`endif

    assign busy       = r_busy;
    assign err        = r_err;
    assign res_valid  = r_res_valid;
    assign res_chan   = r_res_chan;
    assign res_data   = r_res_data;
    assign ms_adc_clk = r_adc_clk;
    assign ms_adc_soc = r_soc;
    assign ms_afe_sel = r_sel;

endmodule

// File: tb/tb_adc_sequencer.sv
`timescale 1ns/1ps
// tb_adc_sequencer: randomized channel-list passes against a pass-level reference model,
// with a behavioural ADC that answers each SOC with a delayed EOC pulse.
module tb_adc_sequencer;
    localparam int CLK_DIV = 4;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 1024;

    logic        ms_osc = 1'b0;
    logic        ms_hporb = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  ch_en = 5'd0;
    logic        busy, err, res_valid;
    logic [2:0]  res_chan;
    logic [11:0] res_data;
    logic        ms_adc_clk, ms_adc_soc;
    logic        ms_adc_eoc = 1'b0;
    logic [11:0] ms_adc_data = 12'd0;
    logic [3:0]  ms_afe_sel, ms_afe_phase;
    logic        ms_afe_phase_update;

    always #5 ms_osc = ~ms_osc;

    adc_sequencer #(.CLK_DIV(CLK_DIV), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .ms_osc(ms_osc), .ms_hporb(ms_hporb), .start(start), .ch_en(ch_en),
        .busy(busy), .err(err), .res_valid(res_valid), .res_chan(res_chan), .res_data(res_data),
        .ms_adc_clk(ms_adc_clk), .ms_adc_soc(ms_adc_soc), .ms_adc_eoc(ms_adc_eoc),
        .ms_adc_data(ms_adc_data), .ms_afe_sel(ms_afe_sel), .ms_afe_phase(ms_afe_phase),
        .ms_afe_phase_update(ms_afe_phase_update)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sel_map[5] = '{1, 2, 4, 5, 6};

    int res_chan_q[$], res_data_q[$], soc_sel_q[$], soc_phase_q[$], adc_log[$], force_q[$];
    int upd_cnt = 0, res_total = 0;
    int last_res_cyc = 0, busy_fall_cyc = 0, soc_fall_cyc = 0, soc_rise_cyc = 0;
    int err_rise_cyc = 0, last_eoc_cyc = 0, last_change_cyc = 0;
    bit adc_dead = 1'b0;
    int adc_delay_fix = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic bit is_spun(input int ch);
`ifdef ADC_SPINNING_EN
        return ch >= 2;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge ms_osc) cyc++;

    // Interface monitor: logs SOCs and results, checks SOC placement and width, result latency.
    logic [3:0] p_sel, p_phase;
    logic       p_soc, p_adc_clk, p_err, p_busy;
    bit         p_valid = 1'b0;
    always @(negedge ms_osc) begin
        if (!ms_hporb) begin
            p_valid = 1'b0;
        end else begin
            if (p_valid) begin
                if (ms_afe_sel != p_sel || ms_afe_phase != p_phase) last_change_cyc = cyc;
                if (ms_adc_soc && !p_soc) begin
                    check("soc_on_adc_clk_rise", {p_adc_clk, ms_adc_clk}, 2'b01);
                    check("soc_after_settle", (cyc - last_change_cyc) >= SETTLE, 1);
                    soc_sel_q.push_back(int'(ms_afe_sel));
                    soc_phase_q.push_back(int'(ms_afe_phase));
                    soc_rise_cyc = cyc;
                end
                if (!ms_adc_soc && p_soc) begin
                    check("soc_width", cyc - soc_rise_cyc, 2 * CLK_DIV);
                    soc_fall_cyc = cyc;
                end
                if (ms_afe_phase_update) begin
                    upd_cnt++;
                    check("update_with_phase_change", ms_afe_phase != p_phase, 1);
                end
                if (res_valid) begin
                    res_chan_q.push_back(int'(res_chan));
                    res_data_q.push_back(int'(res_data));
                    res_total++;
                    last_res_cyc = cyc;
                    check("res_latency_from_eoc", cyc - last_eoc_cyc, 3);
                end
                if (err && !p_err) err_rise_cyc = cyc;
                if (!busy && p_busy) busy_fall_cyc = cyc;
            end
            p_sel = ms_afe_sel; p_phase = ms_afe_phase; p_soc = ms_adc_soc;
            p_adc_clk = ms_adc_clk; p_err = err; p_busy = busy;
            p_valid = 1'b1;
        end
    end

    // Behavioural ADC: after each SOC falls, waits a random delay then raises EOC with a sample for 4 cycles.
    int  adc_wait = 0, adc_hold = 0, adc_d = 0;
    bit  adc_pend = 1'b0;
    logic q_soc = 1'b0;
    always @(negedge ms_osc) begin
        if (!ms_hporb) begin
            ms_adc_eoc = 1'b0; adc_pend = 1'b0; adc_hold = 0; q_soc = 1'b0;
        end else begin
            if (adc_hold > 0) begin
                adc_hold--;
                if (adc_hold == 0) ms_adc_eoc = 1'b0;
            end
            if (adc_pend) begin
                if (adc_wait == 0) begin
                    adc_d = (force_q.size() > 0) ? force_q.pop_front() : int'($urandom_range(0, 4095));
                    ms_adc_data = 12'(adc_d);
                    ms_adc_eoc  = 1'b1;
                    adc_log.push_back(adc_d);
                    last_eoc_cyc = cyc;
                    adc_hold = 4;
                    adc_pend = 1'b0;
                end else begin
                    adc_wait--;
                end
            end
            if (q_soc && !ms_adc_soc && !adc_dead) begin
                adc_pend = 1'b1;
                adc_wait = (adc_delay_fix != 0) ? adc_delay_fix : int'($urandom_range(1, 12));
            end
            q_soc = ms_adc_soc;
        end
    end

    task automatic clear_logs();
        res_chan_q.delete(); res_data_q.delete(); soc_sel_q.delete();
        soc_phase_q.delete(); adc_log.delete(); upd_cnt = 0;
    endtask

    task automatic pulse_start(input logic [4:0] mask);
        @(negedge ms_osc); start = 1'b1; ch_en = mask;
        @(negedge ms_osc); start = 1'b0; ch_en = 5'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge ms_osc);
            n++;
        end
        check("pass_finished_in_budget", busy, 0);
        @(negedge ms_osc);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_chan", res_chan, 0);
        check("rst_res_data", res_data, 0);
        check("rst_adc_clk", ms_adc_clk, 0);
        check("rst_soc", ms_adc_soc, 0);
        check("rst_sel", ms_afe_sel, 0);
        check("rst_phase", ms_afe_phase, 1);
        check("rst_phase_update", ms_afe_phase_update, 0);
    endtask

    // One full pass; expectations are rebuilt from the enabled list and the samples the ADC handed out.
    task automatic run_pass(input logic [4:0] mask, input bit poke);
        int lo, idx, nconv, s;
        int exp_chan[$], exp_data[$], exp_sel[$], exp_phase[$];
        clear_logs();
        lo = 0;
        for (int c = 4; c >= 0; c--) if (mask[c]) lo = c;
        pulse_start(mask);
        check("busy_rise", busy, 1);
        check("sel_first", ms_afe_sel, sel_map[lo]);
        if (poke) begin
            repeat (20) @(negedge ms_osc);
            pulse_start(5'h1F);
            check("busy_during_poke", busy, 1);
        end
        wait_idle(20000);
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            if (mask[c]) begin
                nconv = is_spun(c) ? 4 : 1;
                s = 0;
                for (int p = 0; p < nconv; p++) begin
                    exp_sel.push_back(sel_map[c]);
                    exp_phase.push_back(1 << p);
                    if (idx < adc_log.size()) s += adc_log[idx];
                    idx++;
                end
                exp_chan.push_back(c);
                exp_data.push_back(nconv == 1 ? s : s / 4);
            end
        end
        check("n_results", res_chan_q.size(), exp_chan.size());
        check("n_socs", soc_sel_q.size(), exp_sel.size());
        for (int k = 0; k < exp_chan.size() && k < res_chan_q.size(); k++) begin
            check("res_chan", res_chan_q[k], exp_chan[k]);
            check("res_data", res_data_q[k], exp_data[k]);
        end
        for (int k = 0; k < exp_sel.size() && k < soc_sel_q.size(); k++) begin
            check("sel_at_soc", soc_sel_q[k], exp_sel[k]);
            check("phase_at_soc", soc_phase_q[k], exp_phase[k]);
        end
        check("busy_fall_after_last_res", busy_fall_cyc - last_res_cyc, 1);
        check("err_clear", err, 0);
        check("sel_parked", ms_afe_sel, 0);
        check("phase_parked", ms_afe_phase, 1);
    endtask

    initial begin
        int n;
        int snap;
        repeat (3) @(negedge ms_osc);
        check_reset_outputs();
        ms_hporb = 1'b1;
        n = 0;
        while (!ms_adc_clk && n < 50) begin
            @(negedge ms_osc);
            n++;
        end
        check("adc_clk_first_rise", n, CLK_DIV);

        force_q = '{12'h3FF};
        run_pass(5'b00001, 1'b0);
        if (res_data_q.size() > 0) check("single_3ff", res_data_q[0], 12'h3FF);

        run_pass(5'b10110, 1'b0);

        force_q = '{100, 200, 300, 404};
        run_pass(5'b00100, 1'b0);
`ifdef ADC_SPINNING_EN
        if (res_data_q.size() > 0) check("spin_average", res_data_q[0], 251);
        check("spin_update_strobes", upd_cnt, 3);
`else
        if (res_data_q.size() > 0) check("no_spin_single", res_data_q[0], 100);
        check("no_spin_update_strobes", upd_cnt, 0);
`endif
        force_q.delete();

        for (int i = 0; i < 6; i++) run_pass(5'($urandom_range(1, 31)), i == 2);

        clear_logs();
        pulse_start(5'b00000);
        repeat (40) @(negedge ms_osc);
        check("zero_mask_busy", busy, 0);
        check("zero_mask_no_soc", soc_sel_q.size(), 0);

        clear_logs();
        adc_dead = 1'b1;
        pulse_start(5'b00001);
        wait_idle(3000);
        check("timeout_err", err, 1);
        check("timeout_no_result", res_chan_q.size(), 0);
        check("timeout_delay", err_rise_cyc - soc_fall_cyc, TIMEOUT);
        check("timeout_busy_fall", busy_fall_cyc - err_rise_cyc, 1);
        adc_dead = 1'b0;
        run_pass(5'b00011, 1'b0);

        clear_logs();
        adc_delay_fix = 300;
        pulse_start(5'b00001);
        n = 0;
        while (!(soc_sel_q.size() > 0 && !ms_adc_soc) && n < 500) begin
            @(negedge ms_osc);
            n++;
        end
        check("reached_wait", soc_sel_q.size() > 0 && !ms_adc_soc, 1);
        repeat (20) @(negedge ms_osc);
        #2 ms_hporb = 1'b0;
        #1 check_reset_outputs();
        snap = res_total;
        repeat (3) @(negedge ms_osc);
        ms_hporb = 1'b1;
        repeat (400) @(negedge ms_osc);
        check("no_result_after_reset", res_total - snap, 0);
        check("idle_after_reset", busy, 0);
        adc_delay_fix = 0;
        run_pass(5'b00001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sequencer.md
# adc_sequencer

Digital-side controller for the mixed-signal ADC/AFE interface. It generates the ADC conversion clock and drives the analog mux select. It also issues start-of-conversion, waits for end-of-conversion, captures the 12-bit result and steps through a programmable channel list. Hall channels are optionally spun over four plate phases and averaged. It sits inside the digital top, between the register/TAP logic and the `ms_adc_*` / `ms_afe_*` pins.

## Interface
- `CLK_DIV`, 4: ms_adc_clk half-period in ms_osc cycles (≥1).
- `SETTLE`, 16: ms_osc cycles waited after every mux/phase change before SOC (≥1).
- `TIMEOUT`, 1024: ms_osc cycles allowed from SOC deassertion to EOC.
- `ms_osc  in  1`  system clock.
- `ms_hporb  in  1`  asynchronous active-low reset.
- `start  in  1`  one-cycle pulse; launches one pass over enabled channels.
- `ch_en  in  5`  channel enables; bit0→sel 1, bit1→2, bit2→4, bit3→5, bit4→6; sampled at start.
- `busy  out  1`  high from accepted start to end of pass.
- `err  out  1`  sticky timeout flag; cleared by next accepted start.
- `res_valid  out  1`  one-cycle strobe per completed channel.
- `res_chan  out  3`  ch_en bit index of the result.
- `res_data  out  12`  conversion result (phase average for spun channels).
- `ms_adc_clk  out  1`  ADC clock.
- `ms_adc_soc  out  1`  start of conversion.
- `ms_adc_eoc  in  1`  end of conversion, from the ADC domain.
- `ms_adc_data  in  12`  ADC result, valid while eoc high.
- `ms_afe_sel  out  4`  analog mux select.
- `ms_afe_phase  out  4`  one-hot hall spinning phase.
- `ms_afe_phase_update  out  1`  one-cycle strobe on phase change.

## Operation
- ms_adc_clk: free-running divider out of reset; toggles every CLK_DIV ms_osc cycles; first rising edge CLK_DIV cycles after reset release.
- FSM states: IDLE → SETUP → SOC → WAIT → STORE → (SETUP | DONE) → IDLE.
- IDLE: start with ch_en≠0 latches ch_en, clears err, sets busy, and selects the lowest enabled index. Otherwise start is ignored.
- SETUP: drive ms_afe_sel for the current channel; count SETTLE cycles, then go to SOC.
- SOC: wait for the next ms_adc_clk rising edge; assert ms_adc_soc for exactly 2·CLK_DIV cycles (one full ADC clock period, covering one falling edge).
- WAIT: 2-flop synchronizer on ms_adc_eoc plus rising-edge detect. On detect, sample ms_adc_data and go to STORE. If TIMEOUT cycles elapse first, set err, discard the channel and advance.
- STORE: accumulate into a 14-bit accumulator. When the channel is complete, pulse res_valid with res_chan/res_data. Advance to the next enabled index, or DONE.
- DONE: ms_afe_sel←0, ms_afe_phase←4'b0001, busy←0, return to IDLE.
- start while busy: ignored. ch_en changes mid-pass: ignored.
- eoc already high at SOC: only a new rising edge after synchronization counts.

## Timing
- Reset values:
  - ms_adc_clk=0, ms_adc_soc=0, ms_afe_sel=0, ms_afe_phase=4'b0001, ms_afe_phase_update=0
  - busy=0, err=0, res_valid=0, res_chan=0, res_data=0
  - FSM=IDLE, accumulator=0
- Reset assertion mid-pass forces all of the above immediately, with no completion strobe.
- busy rises the cycle after start; ms_afe_sel changes on that same cycle.
- SOC rises on the first ms_osc edge where ms_adc_clk goes 0→1, no earlier than SETTLE cycles after the sel/phase change.
- res_valid fires 1 cycle after the eoc edge is detected, which is 3 cycles after eoc rises (2 sync + 1).
- busy falls 1 cycle after the last res_valid, or after the last timeout.
- Arithmetic: accumulator is zero-extended sum, 14 bits. Single conversion: res_data = sample. Spun: res_data = sum[13:2] (truncating).

## Configuration
- `ADC_SPINNING_EN` defined: channels 2, 3, 4 (sel 4, 5, 6) run four conversions.
  - Phases: 0001, 0010, 0100, 1000.
  - Each phase change pulses ms_afe_phase_update for one cycle, coincident with the new ms_afe_phase value, and re-enters SETUP.
  - One res_valid is issued after the fourth conversion.
  - A timeout on any phase aborts that channel.
  - Channels 0 and 1 convert once at phase 0001.
- Not defined: every channel converts once; ms_afe_phase is held at 4'b0001; ms_afe_phase_update is tied to 0.

## Test plan
- CLK_DIV=4, ch_en=5'b00001, ADC model returns 12'h3FF → sel=1, one SOC 8 cycles wide, res_valid with res_chan=0, res_data=12'h3FF, busy falls 1 cycle later, err=0.
- ch_en=5'b10110 → res_chan sequence 1, 2, 4; sel sequence 2, 4, 6 then 0; SOC starts ≥16 cycles after each sel change.
- ADC_SPINNING_EN, ch_en=5'b00100, phase samples 100, 200, 300, 404 → phases 0001→0010→0100→1000 with 3 update strobes; one res_valid, res_data=251.
- ms_adc_eoc held low → err=1 after 1024 cycles, no res_valid, busy falls. A following start with eoc working clears err.
- start pulsed while busy, and start with ch_en=0 → no new pass, busy unchanged.
- ms_hporb asserted during WAIT → all outputs at reset values the same cycle. After release, a fresh start completes normally.
